// File: rtl/io_console_pkg.sv
// io_console_pkg
// Shared definitions for the io_console block: feeder FSM state encoding
// and the default geometry/timing parameters.
package io_console_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PRESS   = 3'd2,
    RELEASE = 3'd3,
    HALTED  = 3'd4
  } feed_state_e;

  localparam int DEPTH_DEF = 8;  // entries per queue, power of two 2..16
  localparam int HOLD_DEF  = 4;  // cycles proc_enter stays high per byte
  localparam int GAP_DEF   = 4;  // low cycles after each enter pulse

endpackage

// File: rtl/io_console_byte_fifo.sv
// byte_fifo
// Byte-wide synchronous FIFO with power-of-two depth. Pointers carry one
// extra wrap bit so full and empty can be told apart without a counter.
// Ports:
//   clk, reset       clock, async active-high reset (empties the queue)
//   push_i, wdata_i  enqueue request and data
//   pop_i            dequeue request (ignored while empty)
//   rdata_o          head entry, combinational
//   full_o, empty_o  occupancy flags
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // A push into a full queue is accepted only when a pop frees the head slot
  // in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/io_console.sv
// io_console
// Bridges a host to a simple processor console. Host bytes are queued and
// presented one at a time on proc_in with an enter strobe; every change on
// the processor output port is captured into a second queue for the host.
// Ports:
//   clk, reset                  clock, async active-high reset
//   host_wr, host_wdata         push a byte towards the processor
//   host_full                   input queue full
//   proc_in, proc_enter         data and strobe to the processor
//   proc_out, proc_halt         processor output port and halt flag
//   host_rd, host_rdata         pop / head of the captured-output queue
//   host_valid                  output queue non-empty
//   done, ovf                   sticky halt-seen / capture-dropped flags
module io_console
  import io_console_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int HOLD  = HOLD_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_wr,
  input  logic [7:0] host_wdata,
  output logic       host_full,
  output logic [7:0] proc_in,
  output logic       proc_enter,
  input  logic [7:0] proc_out,
  input  logic       proc_halt,
  input  logic       host_rd,
  output logic [7:0] host_rdata,
  output logic       host_valid,
  output logic       done,
  output logic       ovf
);

  feed_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  proc_in_q, proc_in_d;
  logic [7:0]  last_out_q;
  logic        done_q, ovf_q;

  logic [7:0]  in_head;
  logic        in_empty, in_pop;
  logic        out_full, out_empty, cap_push;

  byte_fifo #(.DEPTH(DEPTH)) u_in_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (host_wr && !host_full),
    .wdata_i (host_wdata),
    .pop_i   (in_pop),
    .rdata_o (in_head),
    .full_o  (host_full),
    .empty_o (in_empty)
  );

  assign cap_push = (proc_out != last_out_q);

  byte_fifo #(.DEPTH(DEPTH)) u_out_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cap_push),
    .wdata_i (proc_out),
    .pop_i   (host_rd),
    .rdata_o (host_rdata),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  // cnt_q is a down-counter loaded on entry to PRESS/RELEASE; the state is
  // left when it reaches zero, giving HOLD and GAP cycles respectively.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    proc_in_d = proc_in_q;
    in_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!in_empty) begin
          state_d   = SETUP;
          proc_in_d = in_head;
        end
      end
      SETUP: begin
        state_d = PRESS;
        cnt_d   = 8'(HOLD - 1);
      end
      PRESS: begin
        if (cnt_q == 8'd0) begin
          state_d = RELEASE;
          cnt_d   = 8'(GAP - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RELEASE: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          in_pop  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
    // Halt overrides everything; the byte in flight stays queued.
    if (proc_halt) begin
      state_d   = HALTED;
      in_pop    = 1'b0;
      proc_in_d = proc_in_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      proc_in_q  <= '0;
      last_out_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      proc_in_q  <= proc_in_d;
      last_out_q <= proc_out;
      if (proc_halt) done_q <= 1'b1;
      if (cap_push && out_full && !host_rd) ovf_q <= 1'b1;
    end
  end

  // Strobe decoded straight from the state register so reset drops it
  // without waiting for a clock edge.
  assign proc_enter = (state_q == PRESS);
  assign proc_in    = proc_in_q;
  assign host_valid = !out_empty;
  assign done       = done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_io_console.sv
module tb_io_console;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_wr = 1'b0;
  logic [7:0] host_wdata = 8'h00;
  logic       host_full;
  logic [7:0] proc_in;
  logic       proc_enter;
  logic [7:0] proc_out = 8'h00;
  logic       proc_halt = 1'b0;
  logic       host_rd = 1'b0;
  logic [7:0] host_rdata;
  logic       host_valid;
  logic       done;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  io_console dut (
    .clk        (clk),
    .reset      (reset),
    .host_wr    (host_wr),
    .host_wdata (host_wdata),
    .host_full  (host_full),
    .proc_in    (proc_in),
    .proc_enter (proc_enter),
    .proc_out   (proc_out),
    .proc_halt  (proc_halt),
    .host_rd    (host_rd),
    .host_rdata (host_rdata),
    .host_valid (host_valid),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int npulse, len, lowrun, gap;
    logic prev;
    logic [7:0] pdata [2];
    int plen [2];
    int highs;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_proc_in", proc_in, 8'h00);
    chk("rst_enter", proc_enter, 1'b0);
    chk("rst_valid", host_valid, 1'b0);
    chk("rst_full", host_full, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    reset = 1'b0;
    tick();

    // Two bytes through the feeder
    host_wr = 1'b1; host_wdata = 8'h05;
    tick();
    host_wdata = 8'h0A;
    tick();
    host_wr = 1'b0;
    chk("setup_data", proc_in, 8'h05);
    chk("setup_enter", proc_enter, 1'b0);
    npulse = 0; len = 0; lowrun = 0; gap = -1; prev = 1'b0;
    pdata[0] = '0; pdata[1] = '0; plen[0] = 0; plen[1] = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (proc_enter && !prev) begin
        if (npulse == 1) gap = lowrun;
        if (npulse < 2) pdata[npulse] = proc_in;
        npulse++;
        len = 0;
      end
      if (proc_enter) len++;
      if (!proc_enter && prev && npulse <= 2) plen[npulse-1] = len;
      if (!proc_enter) lowrun++; else lowrun = 0;
      prev = proc_enter;
    end
    chk("pulse_count", npulse, 2);
    chk("pulse0_len", plen[0], 4);
    chk("pulse1_len", plen[1], 4);
    chk("pulse0_data", pdata[0], 8'h05);
    chk("pulse1_data", pdata[1], 8'h0A);
    chk("pulse_gap", gap, 6);
    chk("idle_hold_data", proc_in, 8'h0A);
    chk("idle_enter", proc_enter, 1'b0);

    // Capture 0x00 -> 0x11 -> 0x11 -> 0x22
    proc_out = 8'h11; tick();
    tick();
    proc_out = 8'h22; tick();
    chk("cap_valid", host_valid, 1'b1);
    chk("cap_head0", host_rdata, 8'h11);
    host_rd = 1'b1; tick(); host_rd = 1'b0;
    chk("cap_head1", host_rdata, 8'h22);
    chk("cap_valid1", host_valid, 1'b1);
    host_rd = 1'b1; tick(); host_rd = 1'b0;
    chk("cap_empty", host_valid, 1'b0);
    host_rd = 1'b1; tick(); host_rd = 1'b0;
    chk("rd_empty_ignored", host_valid, 1'b0);

    // Nine changes with no reads -> overflow, first eight kept
    for (int i = 0; i < 9; i++) begin
      proc_out = 8'h31 + 8'(i);
      tick();
      if (i == 7) chk("ovf_before", ovf, 1'b0);
    end
    chk("ovf_set", ovf, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_entry", host_rdata, 8'h31 + 8'(i));
      host_rd = 1'b1; tick(); host_rd = 1'b0;
    end
    chk("ovf_drained", host_valid, 1'b0);

    // Halt during PRESS
    host_wr = 1'b1; host_wdata = 8'h41; tick();
    host_wdata = 8'h42; tick();
    host_wr = 1'b0;
    tick();
    chk("press_enter", proc_enter, 1'b1);
    chk("press_data", proc_in, 8'h41);
    proc_halt = 1'b1; tick(); proc_halt = 1'b0;
    chk("halt_enter", proc_enter, 1'b0);
    chk("halt_done", done, 1'b1);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (proc_enter) highs++;
    end
    chk("halt_no_enter", highs, 0);
    chk("halt_done_sticky", done, 1'b1);

    // Fill input queue while halted: 2 held + 6 more = 8
    for (int i = 0; i < 6; i++) begin
      host_wr = 1'b1; host_wdata = 8'h50 + 8'(i); tick();
      if (i == 4) chk("fill7_not_full", host_full, 1'b0);
    end
    host_wr = 1'b0;
    chk("fill8_full", host_full, 1'b1);
    host_wr = 1'b1; host_wdata = 8'h99; tick(); host_wr = 1'b0;
    chk("fill9_full", host_full, 1'b1);

    // Capture still active while halted
    proc_out = 8'h77; tick();
    chk("halt_cap_valid", host_valid, 1'b1);
    chk("halt_cap_data", host_rdata, 8'h77);

    // Reset, then reset again mid-PRESS
    reset = 1'b1; proc_out = 8'h00; tick();
    reset = 1'b0; tick();
    host_wr = 1'b1; host_wdata = 8'h55; tick();
    host_wr = 1'b0;
    tick();
    tick();
    chk("rp_enter", proc_enter, 1'b1);
    chk("rp_data", proc_in, 8'h55);
    #2 reset = 1'b1;
    #1;
    chk("rp_async_enter", proc_enter, 1'b0);
    chk("rp_proc_in", proc_in, 8'h00);
    chk("rp_valid", host_valid, 1'b0);
    chk("rp_full", host_full, 1'b0);
    chk("rp_done", done, 1'b0);
    chk("rp_ovf", ovf, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (proc_enter) highs++;
    end
    chk("rp_discarded", highs, 0);
    chk("rp_after_valid", host_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_console.md
IO_CONSOLE -- requirements
Module: io_console

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning entries in each queue (power of two, 2..16).
REQ-002 The block SHALL have parameter HOLD, default 4, meaning cycles proc_enter stays high per byte.
REQ-003 The block SHALL have parameter GAP, default 4, meaning low cycles after each enter pulse before the next byte.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port host_wr, input, 1, which pushes host_wdata into the input queue.
REQ-007 The block SHALL have port host_wdata, input, 8, the byte destined for the processor.
REQ-008 The block SHALL have port host_full, output, 1, meaning the input queue holds DEPTH bytes.
REQ-009 The block SHALL have port proc_in, output, 8, the data driven to the processor input port.
REQ-010 The block SHALL have port proc_enter, output, 1, the enter strobe to the processor.
REQ-011 The block SHALL have port proc_out, input, 8, the processor output port.
REQ-012 The block SHALL have port proc_halt, input, 1, the processor halt flag.
REQ-013 The block SHALL have port host_rd, input, 1, which pops the output queue.
REQ-014 The block SHALL have port host_rdata, output, 8, the head of the output queue.
REQ-015 The block SHALL have port host_valid, output, 1, meaning the output queue is non-empty.
REQ-016 The block SHALL have port done, output, 1, meaning halt has been seen (sticky).
REQ-017 The block SHALL have port ovf, output, 1, meaning a captured byte was dropped (sticky).

Function
REQ-018 The feeder FSM SHALL use states IDLE, SETUP, PRESS, RELEASE and HALTED.
REQ-019 IDLE SHALL go to SETUP when the input queue is non-empty; proc_in shows the head byte from SETUP through RELEASE.
REQ-020 SETUP SHALL last exactly 1 cycle with proc_enter low, giving data setup before the strobe.
REQ-021 PRESS SHALL hold proc_enter high for exactly HOLD cycles, then go to RELEASE.
REQ-022 RELEASE SHALL hold proc_enter low for GAP cycles, then pop the head byte and return to IDLE.
REQ-023 A queued byte SHALL occupy 1+HOLD+GAP cycles of the feeder; back-to-back bytes SHALL carry no extra idle cycle beyond the IDLE evaluation cycle.
REQ-024 In IDLE, proc_in SHALL hold the last byte presented (0x00 after reset) and proc_enter SHALL be 0.
REQ-025 host_wr while host_full SHALL be ignored, with no state change; a write and a pop in the same cycle SHALL both take effect.
REQ-026 The capture side SHALL register proc_out into last_out each cycle and push proc_out into the output queue whenever proc_out differs from last_out.
REQ-027 A push when the output queue is full and host_rd is low SHALL drop the byte and set ovf; with host_rd high, push and pop SHALL both succeed.
REQ-028 host_rd while host_valid is low SHALL be ignored; host_rdata SHALL be combinational from the head entry.
REQ-029 proc_halt high in any state SHALL move the FSM to HALTED next cycle, force proc_enter low, and set done.
REQ-030 HALTED SHALL be left only by reset; the input queue SHALL stop draining but still accept writes, and capture and host reads SHALL stay active.
REQ-031 Queue pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL be decoded from the MSB and the lower bits.

Reset
REQ-032 While reset is high the FSM SHALL be IDLE, both queues empty, proc_in=0x00, proc_enter=0, last_out=0x00, done=0, ovf=0, host_valid=0, host_full=0.
REQ-033 Reset asserted mid-PRESS SHALL drop proc_enter low asynchronously and discard the byte in flight.

Structure
REQ-034 The FSM state encoding and the default HOLD, GAP and DEPTH values SHALL live in a shared package, io_console_pkg.
REQ-035 Both queues SHALL be instances of one sub-module, byte_fifo, parameterised by DEPTH.

Verification
REQ-036 Write 0x05 then 0x0A with HOLD=4 and GAP=4: proc_enter is high for 4 cycles per byte, and proc_in is 0x05 during the first pulse and 0x0A during the second.
REQ-037 Write 9 bytes with DEPTH=8 while the feeder is stalled by proc_halt: host_full=1 after the 8th write, and the 9th write is ignored.
REQ-038 Drive proc_out 0x00→0x11→0x11→0x22: exactly 2 entries are queued, host_rdata=0x11 then 0x22 after a host_rd.
REQ-039 Make 9 proc_out changes with no host_rd: ovf=1 and the queue holds the first 8 values.
REQ-040 Assert proc_halt during PRESS: proc_enter=0 and done=1 on the next cycle, and the remaining queued input is held.
REQ-041 Assert reset during PRESS: proc_enter=0 immediately, and all outputs are at reset values.
